// File: rtl/regfile_write_arbiter.sv
// Register-file write-port arbiter with per-register busy scoreboard.
// Round-robins the single write port between the ALU and load writeback
// paths, registers the winning write for one cycle, and tracks which
// registers still have an issued write outstanding.
module regfile_write_arbiter #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned ADDR_WIDTH = 3,
    parameter int unsigned NUM_REGS   = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  issueValid,
    input  logic [ADDR_WIDTH-1:0] issueDest,
    output logic                  issueReady,
    input  logic                  aluValid,
    input  logic [ADDR_WIDTH-1:0] aluDest,
    input  logic [DATA_WIDTH-1:0] aluData,
    output logic                  aluReady,
    input  logic                  memValid,
    input  logic [ADDR_WIDTH-1:0] memDest,
    input  logic [DATA_WIDTH-1:0] memData,
    output logic                  memReady,
    output logic [ADDR_WIDTH-1:0] regDestination,
    output logic [DATA_WIDTH-1:0] writeData,
    output logic                  writeEnable,
    output logic [NUM_REGS-1:0]   busyMask,
    output logic                  strayWrite
);

    typedef enum logic {
        SIDE_ALU = 1'b0,
        SIDE_MEM = 1'b1
    } side_e;

    side_e                 rr_ptr_q, rr_ptr_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] dest_q, dest_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [NUM_REGS-1:0]   busy_q, busy_d;
    logic                  stray_q, stray_d;

    // Grant selection: a lone requester wins; on contention the round-robin side wins.
    always_comb begin
        aluReady = 1'b0;
        memReady = 1'b0;
        if (aluValid && (!memValid || rr_ptr_q == SIDE_ALU)) begin
            aluReady = 1'b1;
        end else if (memValid) begin
            memReady = 1'b1;
        end
    end

    // Issue is held off while the destination still has a write outstanding.
    always_comb begin
        issueReady = ~busy_q[issueDest];
    end

    // Next-state: capture the granted write, rotate priority, update the scoreboard.
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        we_d     = 1'b0;
        dest_d   = dest_q;
        data_d   = data_q;
        busy_d   = busy_q;
        stray_d  = 1'b0;

        // Commit clears first so that a same-edge issue to that register wins.
        if (we_q) begin
            busy_d[dest_q] = 1'b0;
        end
        if (issueValid && issueReady) begin
            busy_d[issueDest] = 1'b1;
        end

        if (aluReady) begin
            we_d     = 1'b1;
            dest_d   = aluDest;
            data_d   = aluData;
            rr_ptr_d = SIDE_MEM;
        end else if (memReady) begin
            we_d     = 1'b1;
            dest_d   = memDest;
            data_d   = memData;
            rr_ptr_d = SIDE_ALU;
        end

        // Stray if the target will not be marked busy during the commit cycle.
        stray_d = we_d && !busy_d[dest_d];
    end

    // State registers; reset drops any in-flight write immediately.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rr_ptr_q <= SIDE_ALU;
            we_q     <= 1'b0;
            dest_q   <= '0;
            data_q   <= '0;
            busy_q   <= '0;
            stray_q  <= 1'b0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            we_q     <= we_d;
            dest_q   <= dest_d;
            data_q   <= data_d;
            busy_q   <= busy_d;
            stray_q  <= stray_d;
        end
    end

    assign writeEnable    = we_q;
    assign regDestination = dest_q;
    assign writeData      = data_q;
    assign busyMask       = busy_q;
    assign strayWrite     = stray_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Self-checking bench for regfile_write_arbiter: directed scenarios plus
// randomized traffic checked against a transaction-level reference model.
module tb_regfile_write_arbiter;

    localparam int unsigned DW = 16;
    localparam int unsigned AW = 3;
    localparam int unsigned NR = 8;

    logic          clock = 1'b0;
    logic          reset;
    logic          issueValid;
    logic [AW-1:0] issueDest;
    logic          issueReady;
    logic          aluValid;
    logic [AW-1:0] aluDest;
    logic [DW-1:0] aluData;
    logic          aluReady;
    logic          memValid;
    logic [AW-1:0] memDest;
    logic [DW-1:0] memData;
    logic          memReady;
    logic [AW-1:0] regDestination;
    logic [DW-1:0] writeData;
    logic          writeEnable;
    logic [NR-1:0] busyMask;
    logic          strayWrite;

    regfile_write_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_REGS(NR)) dut (
        .clock(clock), .reset(reset),
        .issueValid(issueValid), .issueDest(issueDest), .issueReady(issueReady),
        .aluValid(aluValid), .aluDest(aluDest), .aluData(aluData), .aluReady(aluReady),
        .memValid(memValid), .memDest(memDest), .memData(memData), .memReady(memReady),
        .regDestination(regDestination), .writeData(writeData), .writeEnable(writeEnable),
        .busyMask(busyMask), .strayWrite(strayWrite)
    );

    always #5 clock = ~clock;

    // Regfile stand-in driven by the DUT write port.
    logic [DW-1:0] tb_rf [NR];
    always @(posedge clock) begin
        if (writeEnable) tb_rf[regDestination] <= writeData;
    end

    int total = 0;
    int bad   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: which registers are awaiting a write, what the regfile
    // should contain, which side is favoured next, and the write due next cycle.
    bit            m_busy [NR];
    logic [DW-1:0] m_rf   [NR];
    bit            m_favour_mem;
    bit            m_we;
    logic [AW-1:0] m_dest;
    logic [DW-1:0] m_data;
    bit            m_stray;

    task automatic model_reset();
        foreach (m_busy[i]) m_busy[i] = 1'b0;
        m_favour_mem = 1'b0;
        m_we    = 1'b0;
        m_dest  = '0;
        m_data  = '0;
        m_stray = 1'b0;
    endtask

    task automatic drive(input bit iv, input int idst, input bit av, input int adst,
                         input logic [DW-1:0] adat, input bit mv, input int mdst,
                         input logic [DW-1:0] mdat);
        issueValid = iv;  issueDest = AW'(idst);
        aluValid   = av;  aluDest   = AW'(adst); aluData = adat;
        memValid   = mv;  memDest   = AW'(mdst); memData = mdat;
    endtask

    // One clock: check grants before the edge, registered outputs after it.
    task automatic step(output bit ga, output bit gm);
        bit            issue_ok;
        bit            prev_we;
        logic [AW-1:0] prev_dest;
        logic [NR-1:0] exp_mask;
        #1;
        ga = aluValid && (!memValid || !m_favour_mem);
        gm = memValid && !ga;
        issue_ok = !m_busy[issueDest];
        check_eq("alu_ready", 32'(aluReady), 32'(ga));
        check_eq("mem_ready", 32'(memReady), 32'(gm));
        check_eq("issue_ready", 32'(issueReady), 32'(issue_ok));
        @(posedge clock);
        #1;
        prev_we   = m_we;
        prev_dest = m_dest;
        if (m_we) begin
            m_busy[m_dest] = 1'b0;
            m_rf[m_dest]   = m_data;
        end
        if (issueValid && issue_ok) m_busy[issueDest] = 1'b1;
        m_we = ga || gm;
        if (ga) begin
            m_dest = aluDest; m_data = aluData; m_favour_mem = 1'b1;
        end else if (gm) begin
            m_dest = memDest; m_data = memData; m_favour_mem = 1'b0;
        end
        m_stray = m_we && !m_busy[m_dest];
        for (int i = 0; i < NR; i++) exp_mask[i] = m_busy[i];
        check_eq("write_enable", 32'(writeEnable), 32'(m_we));
        if (m_we) begin
            check_eq("reg_dest", 32'(regDestination), 32'(m_dest));
            check_eq("write_data", 32'(writeData), 32'(m_data));
        end
        check_eq("stray_write", 32'(strayWrite), 32'(m_stray));
        check_eq("busy_mask", 32'(busyMask), 32'(exp_mask));
        if (prev_we) check_eq("regfile", 32'(tb_rf[prev_dest]), 32'(m_rf[prev_dest]));
    endtask

    task automatic do_reset();
        @(negedge clock);
        drive(0, 0, 0, 0, '0, 0, 0, '0);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        model_reset();
    endtask

    bit ga, gm;
    bit alu_pend, mem_pend;
    int pick;

    initial begin
        foreach (tb_rf[i]) begin tb_rf[i] = '0; m_rf[i] = '0; end
        drive(0, 0, 0, 0, '0, 0, 0, '0);
        reset = 1'b1;
        model_reset();
        #1;
        check_eq("reset_we", 32'(writeEnable), 32'd0);
        check_eq("reset_dest", 32'(regDestination), 32'd0);
        check_eq("reset_data", 32'(writeData), 32'd0);
        check_eq("reset_mask", 32'(busyMask), 32'd0);
        check_eq("reset_stray", 32'(strayWrite), 32'd0);
        do_reset();

        // Issue R2 then write 0x23FE: one-cycle commit, busy bit drops, regfile updated.
        drive(1, 2, 0, 0, '0, 0, 0, '0);            step(ga, gm);
        @(negedge clock); drive(0, 0, 1, 2, 16'h23FE, 0, 0, '0);
        step(ga, gm);
        check_eq("t2_ready", 32'(ga), 32'd1);
        check_eq("t2_we", 32'(writeEnable), 32'd1);
        check_eq("t2_data", 32'(writeData), 32'h23FE);
        @(negedge clock); drive(0, 0, 0, 0, '0, 0, 0, '0); step(ga, gm);
        check_eq("t2_rf", 32'(tb_rf[2]), 32'h23FE);
        check_eq("t2_busy", 32'(busyMask[2]), 32'd0);

        // Reset while a write is in flight drops it asynchronously.
        @(negedge clock); drive(1, 2, 0, 0, '0, 0, 0, '0); step(ga, gm);
        @(negedge clock); drive(0, 0, 1, 2, 16'h5555, 0, 0, '0); step(ga, gm);
        #2 reset = 1'b1;
        #1;
        check_eq("t1_we", 32'(writeEnable), 32'd0);
        check_eq("t1_mask", 32'(busyMask), 32'd0);
        check_eq("t1_stray", 32'(strayWrite), 32'd0);
        @(negedge clock); reset = 1'b0; drive(0, 0, 0, 0, '0, 0, 0, '0); model_reset();

        // Contention from reset: ALU wins first, load follows next cycle.
        drive(1, 4, 0, 0, '0, 0, 0, '0); step(ga, gm);
        @(negedge clock); drive(1, 5, 0, 0, '0, 0, 0, '0); step(ga, gm);
        @(negedge clock); drive(0, 0, 1, 4, 16'h6781, 1, 5, 16'h1234); step(ga, gm);
        check_eq("t3_first", 32'(writeData), 32'h6781);
        @(negedge clock); drive(0, 0, 0, 0, '0, 1, 5, 16'h1234); step(ga, gm);
        check_eq("t3_second", 32'(writeData), 32'h1234);

        // Both sides write R3: two pulses, only the second is stray.
        @(negedge clock); drive(1, 3, 0, 0, '0, 0, 0, '0); step(ga, gm);
        @(negedge clock); drive(0, 0, 1, 3, 16'h1111, 1, 3, 16'h2222); step(ga, gm);
        check_eq("t4_stray1", 32'(strayWrite), 32'd0);
        @(negedge clock);
        drive(0, 0, !ga, 3, 16'h1111, !gm, 3, 16'h2222); step(ga, gm);
        check_eq("t4_stray2", 32'(strayWrite), 32'd1);
        @(negedge clock); drive(0, 0, 0, 0, '0, 0, 0, '0); step(ga, gm);
        check_eq("t4_rf", 32'(tb_rf[3]), 32'(m_rf[3]));

        // Issue to a busy register stalls until after the commit.
        @(negedge clock); drive(1, 1, 0, 0, '0, 0, 0, '0); step(ga, gm);
        @(negedge clock); drive(1, 1, 1, 1, 16'h0A0A, 0, 0, '0); step(ga, gm);
        check_eq("t5_stall", 32'(issueReady), 32'd0);
        @(negedge clock); drive(1, 1, 0, 0, '0, 0, 0, '0); step(ga, gm);
        check_eq("t5_release", 32'(issueReady), 32'd1);

        // Load write to an idle register is still performed and flagged.
        @(negedge clock); drive(0, 0, 0, 0, '0, 1, 6, 16'hBEEF); step(ga, gm);
        check_eq("t6_stray", 32'(strayWrite), 32'd1);
        check_eq("t6_data", 32'(writeData), 32'hBEEF);

        // Randomized traffic; requesters hold until accepted.
        do_reset();
        alu_pend = 0; mem_pend = 0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            issueValid = 1'($urandom_range(0, 1));
            issueDest  = AW'($urandom_range(0, NR - 1));
            if (!alu_pend && $urandom_range(0, 2) != 0) begin
                alu_pend = 1; aluData = DW'($urandom);
                pick = $urandom_range(0, NR - 1);
                for (int k = 0; k < NR; k++)
                    if (m_busy[(pick + k) % NR] && $urandom_range(0, 3) != 0) begin
                        pick = (pick + k) % NR; break;
                    end
                aluDest = AW'(pick);
            end
            if (!mem_pend && $urandom_range(0, 2) != 0) begin
                mem_pend = 1; memData = DW'($urandom);
                memDest = AW'($urandom_range(0, NR - 1));
            end
            aluValid = alu_pend;
            memValid = mem_pend;
            step(ga, gm);
            if (ga) alu_pend = 0;
            if (gm) mem_pend = 0;
            @(negedge clock);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
